// File: rtl/mccu_fsm.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// timeout watchdog, illegal-opcode trap and retired-instruction counter.
module mccu_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IM_R,
  output logic             DM_CS,
  output logic             DM_R,
  output logic             DM_W,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [1:0]       mux1,
  output logic             mux2,
  output logic             mux3,
  output logic             mux4,
  output logic             mux5,
  output logic             write_reg,
  output logic             s_ext,
  output logic [3:0]       aluc,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;

  state_t           state_r;
  logic [TO_W-1:0]  wait_r;
  logic [CNT_W-1:0] retired_r;
  logic             illegal_r;
  logic             bus_err_r;

  logic       legal_s, is_r_s, is_j_s, is_jal_s, is_jr_s;
  logic       is_beq_s, is_bne_s, is_lw_s, is_sw_s;
  logic [3:0] alu_s;
  logic       shamt_s, imm_s, sext_s;
  logic       taken_s, retire_s, timeout_s;

  assign state   = state_r;
  assign retired = retired_r;
  assign illegal = illegal_r;
  assign bus_err = bus_err_r;

  // Instruction decode of op/func into class flags and ALU controls
  always_comb begin
    legal_s  = 1'b0;
    is_r_s   = 1'b0;
    is_j_s   = 1'b0;
    is_jal_s = 1'b0;
    is_jr_s  = 1'b0;
    is_beq_s = 1'b0;
    is_bne_s = 1'b0;
    is_lw_s  = 1'b0;
    is_sw_s  = 1'b0;
    alu_s    = 4'b0000;
    shamt_s  = 1'b0;
    imm_s    = 1'b0;
    sext_s   = 1'b0;
    case (op)
      OP_R: begin
        legal_s = 1'b1;
        is_r_s  = 1'b1;
        case (func)
          6'b100000: alu_s = 4'b0010;
          6'b100001: alu_s = 4'b0000;
          6'b100010: alu_s = 4'b0011;
          6'b100011: alu_s = 4'b0001;
          6'b100100: alu_s = 4'b0100;
          6'b100101: alu_s = 4'b0101;
          6'b100110: alu_s = 4'b0110;
          6'b100111: alu_s = 4'b0111;
          6'b101010: alu_s = 4'b1011;
          6'b101011: alu_s = 4'b1010;
          6'b000000: begin alu_s = 4'b1110; shamt_s = 1'b1; end
          6'b000010: begin alu_s = 4'b1101; shamt_s = 1'b1; end
          6'b000011: begin alu_s = 4'b1100; shamt_s = 1'b1; end
          6'b000100: alu_s = 4'b1110;
          6'b000110: alu_s = 4'b1101;
          6'b000111: alu_s = 4'b1100;
          6'b001000: is_jr_s = 1'b1;
          default: begin legal_s = 1'b0; is_r_s = 1'b0; end
        endcase
      end
      OP_J:     begin legal_s = 1'b1; is_j_s = 1'b1; end
      OP_JAL:   begin legal_s = 1'b1; is_jal_s = 1'b1; end
      OP_BEQ:   begin legal_s = 1'b1; is_beq_s = 1'b1; alu_s = 4'b0011; sext_s = 1'b1; end
      OP_BNE:   begin legal_s = 1'b1; is_bne_s = 1'b1; alu_s = 4'b0011; sext_s = 1'b1; end
      OP_ADDI:  begin legal_s = 1'b1; alu_s = 4'b0010; imm_s = 1'b1; sext_s = 1'b1; end
      OP_ADDIU: begin legal_s = 1'b1; alu_s = 4'b0000; imm_s = 1'b1; sext_s = 1'b1; end
      OP_SLTI:  begin legal_s = 1'b1; alu_s = 4'b1011; imm_s = 1'b1; sext_s = 1'b1; end
      OP_SLTIU: begin legal_s = 1'b1; alu_s = 4'b1010; imm_s = 1'b1; sext_s = 1'b1; end
      OP_ANDI:  begin legal_s = 1'b1; alu_s = 4'b0100; imm_s = 1'b1; end
      OP_ORI:   begin legal_s = 1'b1; alu_s = 4'b0101; imm_s = 1'b1; end
      OP_XORI:  begin legal_s = 1'b1; alu_s = 4'b0110; imm_s = 1'b1; end
      OP_LUI:   begin legal_s = 1'b1; alu_s = 4'b1000; imm_s = 1'b1; end
      OP_LW:    begin legal_s = 1'b1; is_lw_s = 1'b1; alu_s = 4'b0000; imm_s = 1'b1; sext_s = 1'b1; end
      OP_SW:    begin legal_s = 1'b1; is_sw_s = 1'b1; alu_s = 4'b0000; imm_s = 1'b1; sext_s = 1'b1; end
      default:  legal_s = 1'b0;
    endcase
  end

  assign taken_s   = (is_beq_s & zero) | (is_bne_s & ~zero);
  assign timeout_s = (wait_r == TO_W'(TIMEOUT - 1));

  // Retirement decision; only the MEM completion looks at mem_ready
  always_comb begin
    case (state_r)
      S_DECODE: retire_s = legal_s & (is_j_s | is_jal_s | is_jr_s);
      S_EXEC:   retire_s = is_beq_s | is_bne_s;
      S_MEM:    retire_s = mem_ready & is_sw_s;
      S_WB:     retire_s = 1'b1;
      default:  retire_s = 1'b0;
    endcase
  end

  // Datapath strobes decoded from the current state; ALU controls held EXEC..WB
  always_comb begin
    IM_R = 1'b0; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    ir_we = 1'b0; pc_we = 1'b0; rf_we = 1'b0; mux1 = 2'b00;
    mux2 = 1'b0; mux3 = 1'b0; mux4 = 1'b0; mux5 = 1'b0;
    write_reg = 1'b0; s_ext = 1'b0; aluc = 4'b0000;
    case (state_r)
      S_FETCH: begin
        IM_R  = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
      end
      S_DECODE: begin
        pc_we = legal_s & (is_j_s | is_jal_s | is_jr_s);
        mux1  = (legal_s & is_jr_s) ? 2'b10 : ((legal_s & (is_j_s | is_jal_s)) ? 2'b11 : 2'b00);
        rf_we = legal_s & is_jal_s;
        mux5  = legal_s & is_jal_s;
      end
      S_EXEC: begin
        aluc = alu_s; mux3 = shamt_s; mux4 = imm_s; s_ext = sext_s;
        pc_we = taken_s;
        mux1  = taken_s ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        aluc = alu_s; mux3 = shamt_s; mux4 = imm_s; s_ext = sext_s;
        DM_CS = 1'b1;
        DM_R  = is_lw_s;
        DM_W  = is_sw_s;
      end
      S_WB: begin
        aluc = alu_s; mux3 = shamt_s; mux4 = imm_s; s_ext = sext_s;
        rf_we     = 1'b1;
        write_reg = is_r_s;
        mux2      = is_lw_s;
      end
      default: aluc = 4'b0000;
    endcase
  end

  assign instr_done = retire_s;

  // State sequencing, wait watchdog, sticky trap causes and retirement count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_RST;
      wait_r    <= '0;
      retired_r <= '0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      if (retire_s) retired_r <= retired_r + CNT_W'(1);
      case (state_r)
        S_RST: begin
          state_r <= S_FETCH;
          wait_r  <= '0;
        end
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_r <= '0;
            if (state_r == S_FETCH) state_r <= S_DECODE;
            else                    state_r <= is_sw_s ? S_FETCH : S_WB;
          end else if (timeout_s) begin
            wait_r    <= '0;
            bus_err_r <= 1'b1;
            state_r   <= S_TRAP;
          end else begin
            wait_r <= wait_r + TO_W'(1);
          end
        end
        S_DECODE: begin
          wait_r <= '0;
          if (!legal_s) begin
            illegal_r <= 1'b1;
            state_r   <= S_TRAP;
          end else if (is_j_s | is_jal_s | is_jr_s) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_r <= '0;
          if (is_beq_s | is_bne_s)    state_r <= S_FETCH;
          else if (is_lw_s | is_sw_s) state_r <= S_MEM;
          else                        state_r <= S_WB;
        end
        S_WB: begin
          wait_r  <= '0;
          state_r <= S_FETCH;
        end
        S_TRAP: state_r <= S_TRAP;
        default: begin
          wait_r  <= '0;
          state_r <= S_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mccu_fsm.sv
// Directed bench for mccu_fsm: instruction table walked cycle by cycle, plus
// hand sequences for memory waits, traps, async reset and counter wrap.
module tb_mccu_fsm;

  logic        clk, rst_n, zero, mem_ready;
  logic [5:0]  op, func;
  logic        IM_R, DM_CS, DM_R, DM_W, ir_we, pc_we, rf_we;
  logic [1:0]  mux1;
  logic        mux2, mux3, mux4, mux5, write_reg, s_ext;
  logic [3:0]  aluc;
  logic [2:0]  state;
  logic        instr_done, illegal, bus_err;
  logic [31:0] retired;

  mccu_fsm #(.TIMEOUT(16), .TO_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .IM_R(IM_R), .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .mux1(mux1),
    .mux2(mux2), .mux3(mux3), .mux4(mux4), .mux5(mux5),
    .write_reg(write_reg), .s_ext(s_ext), .aluc(aluc), .state(state),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_JMP = 0, K_BR = 1, K_ALU = 2, K_SW = 3, K_LW = 4;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         kind;
    logic [3:0] aluc;
    logic       m3, m4, se, rtype, taken, jal, jr;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    exp_ret;
  vec_t  tbl[21];
  logic [18:0] ctl;

  assign ctl = {IM_R, DM_CS, DM_R, DM_W, ir_we, pc_we, rf_we, mux1,
                mux2, mux3, mux4, mux5, write_reg, s_ext, aluc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    @(negedge clk);
    op = o; func = f; zero = z; mem_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(ctl), 32'd0);
    chk("reset_sticky", {30'd0, illegal, bus_err}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_hold_state", 32'(state), 32'd0);
    exp_ret = 0;
  endtask

  function automatic vec_t mk(string n, logic [5:0] o, logic [5:0] f, logic z, int k,
                              logic [3:0] a, logic m3, logic m4, logic se, logic rt,
                              logic tk, logic jl, logic jr);
    vec_t v;
    v.name = n; v.op = o; v.func = f; v.zero = z; v.kind = k; v.aluc = a;
    v.m3 = m3; v.m4 = m4; v.se = se; v.rtype = rt; v.taken = tk; v.jal = jl; v.jr = jr;
    return v;
  endfunction

  function automatic int nsteps(int k);
    case (k)
      K_JMP:   return 2;
      K_BR:    return 3;
      K_LW:    return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] exp_state(int k, int s);
    case (s)
      0: return 3'd1;
      1: return 3'd2;
      2: return 3'd3;
      3: return (k == K_ALU) ? 3'd5 : 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [18:0] exp_ctl(vec_t v, logic [2:0] s);
    logic im, cs, dr, dw, ir, pc, rf, m2, m3, m4, m5, wr, se;
    logic [1:0] m1;
    logic [3:0] al;
    {im, cs, dr, dw, ir, pc, rf, m2, m3, m4, m5, wr, se} = 13'd0;
    m1 = 2'b00; al = 4'b0000;
    if (s >= 3'd3) begin al = v.aluc; m3 = v.m3; m4 = v.m4; se = v.se; end
    case (s)
      3'd1: begin im = 1'b1; ir = 1'b1; pc = 1'b1; end
      3'd2: if (v.kind == K_JMP) begin
              pc = 1'b1; m1 = v.jr ? 2'b10 : 2'b11; rf = v.jal; m5 = v.jal;
            end
      3'd3: if (v.kind == K_BR) begin pc = v.taken; m1 = v.taken ? 2'b01 : 2'b00; end
      3'd4: begin cs = 1'b1; dr = (v.kind == K_LW); dw = (v.kind == K_SW); end
      3'd5: begin rf = 1'b1; wr = v.rtype; m2 = (v.kind == K_LW); end
      default: ;
    endcase
    return {im, cs, dr, dw, ir, pc, rf, m1, m2, m3, m4, m5, wr, se, al};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = mk("add",   6'o00, 6'b100000, 1'b0, K_ALU, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk("sub",   6'o00, 6'b100010, 1'b0, K_ALU, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk("and",   6'o00, 6'b100100, 1'b0, K_ALU, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk("nor",   6'o00, 6'b100111, 1'b0, K_ALU, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk("sltu",  6'o00, 6'b101011, 1'b0, K_ALU, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk("sll",   6'o00, 6'b000000, 1'b0, K_ALU, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk("srl",   6'o00, 6'b000010, 1'b0, K_ALU, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk("srav",  6'o00, 6'b000111, 1'b0, K_ALU, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk("addi",  6'b001000, 6'd0, 1'b0, K_ALU, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk("ori",   6'b001101, 6'd0, 1'b0, K_ALU, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk("sltiu", 6'b001011, 6'd0, 1'b0, K_ALU, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk("lui",   6'b001111, 6'd0, 1'b0, K_ALU, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk("lw",    6'b100011, 6'd0, 1'b0, K_LW,  4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk("sw",    6'b101011, 6'd0, 1'b0, K_SW,  4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk("beq_t", 6'b000100, 6'd0, 1'b1, K_BR,  4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk("beq_n", 6'b000100, 6'd0, 1'b0, K_BR,  4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk("bne_t", 6'b000101, 6'd0, 1'b0, K_BR,  4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk("bne_n", 6'b000101, 6'd0, 1'b1, K_BR,  4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk("j",     6'b000010, 6'd0, 1'b0, K_JMP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk("jal",   6'b000011, 6'd0, 1'b0, K_JMP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[20] = mk("jr",    6'o00, 6'b001000, 1'b0, K_JMP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0; op = 6'd0; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    do_reset();

    // Table: every instruction with zero-wait memory, checked each cycle
    foreach (tbl[i]) begin
      for (int s = 0; s < nsteps(tbl[i].kind); s++) begin
        step(tbl[i].op, tbl[i].func, tbl[i].zero, 1'b1);
        if (s == 0) chk({tbl[i].name, "_retired"}, retired, 32'(exp_ret));
        chk({tbl[i].name, "_state"}, 32'(state), 32'(exp_state(tbl[i].kind, s)));
        chk({tbl[i].name, "_ctl"}, 32'(ctl), 32'(exp_ctl(tbl[i], exp_state(tbl[i].kind, s))));
        chk({tbl[i].name, "_done"}, 32'(instr_done), 32'(s == nsteps(tbl[i].kind) - 1));
      end
      exp_ret++;
    end

    // lw with three MEM wait cycles: 8 cycles total
    step(6'b100011, 6'd0, 1'b0, 1'b1);
    chk("lww_fetch", 32'(state), 32'd1);
    chk("lww_retired", retired, 32'(exp_ret));
    step(6'b100011, 6'd0, 1'b0, 1'b1);
    step(6'b100011, 6'd0, 1'b0, 1'b1);
    chk("lww_exec", 32'(state), 32'd3);
    for (int w = 0; w < 4; w++) begin
      step(6'b100011, 6'd0, 1'b0, (w == 3));
      chk("lww_mem_state", 32'(state), 32'd4);
      chk("lww_mem_strb", {29'd0, DM_CS, DM_R, DM_W}, 32'b110);
      chk("lww_mem_done", 32'(instr_done), 32'd0);
    end
    step(6'b100011, 6'd0, 1'b0, 1'b1);
    chk("lww_wb", {27'd0, state, mux2, rf_we}, {27'd0, 3'd5, 1'b1, 1'b1});
    chk("lww_done", 32'(instr_done), 32'd1);
    exp_ret++;

    // sw stalled in MEM, then async reset in mid-cycle kills strobes at once
    step(6'b101011, 6'd0, 1'b0, 1'b1);
    chk("swr_retired", retired, 32'(exp_ret));
    step(6'b101011, 6'd0, 1'b0, 1'b1);
    step(6'b101011, 6'd0, 1'b0, 1'b1);
    step(6'b101011, 6'd0, 1'b0, 1'b0);
    chk("swr_mem", {29'd0, DM_CS, DM_R, DM_W}, 32'b101);
    #1 rst_n = 1'b0;
    #1;
    chk("swr_async_strb", {29'd0, DM_CS, DM_R, DM_W}, 32'd0);
    chk("swr_async_state", 32'(state), 32'd0);
    chk("swr_async_ret", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    exp_ret = 0;

    // Illegal opcode traps from DECODE with no writes, held until reset
    step(6'b111111, 6'd0, 1'b0, 1'b1);
    chk("ill_fetch", 32'(state), 32'd1);
    step(6'b111111, 6'd0, 1'b0, 1'b1);
    chk("ill_decode", 32'(state), 32'd2);
    chk("ill_dec_ctl", 32'(ctl), 32'd0);
    chk("ill_dec_done", 32'(instr_done), 32'd0);
    for (int t = 0; t < 4; t++) begin
      step(6'b111111, 6'd0, 1'b0, t[0]);
      chk("ill_trap_state", 32'(state), 32'd6);
      chk("ill_trap_flags", {30'd0, illegal, bus_err}, 32'b10);
      chk("ill_trap_ctl", 32'(ctl), 32'd0);
      chk("ill_trap_ret", retired, 32'd0);
    end
    do_reset();

    // mem_ready low in FETCH: bus error after 16 waiting cycles
    for (int c = 1; c <= 16; c++) begin
      step(6'd0, 6'b100000, 1'b0, 1'b0);
      chk("bus_fetch_state", 32'(state), 32'd1);
      chk("bus_fetch_we", {30'd0, ir_we, pc_we}, 32'd0);
      chk("bus_not_yet", 32'(bus_err), 32'd0);
    end
    for (int t = 0; t < 3; t++) begin
      step(6'd0, 6'b100000, 1'b0, t[0]);
      chk("bus_trap_state", 32'(state), 32'd6);
      chk("bus_trap_flags", {30'd0, illegal, bus_err}, 32'b01);
      chk("bus_trap_ctl", 32'(ctl), 32'd0);
    end
    do_reset();

    // Counter wrap: preload all-ones, retire a j
    force dut.retired_r = 32'hFFFF_FFFF;
    #1 release dut.retired_r;
    #1;
    chk("wrap_preload", retired, 32'hFFFF_FFFF);
    step(6'b000010, 6'd0, 1'b0, 1'b1);
    step(6'b000010, 6'd0, 1'b0, 1'b1);
    chk("wrap_done", 32'(instr_done), 32'd1);
    step(6'b000010, 6'd0, 1'b0, 1'b1);
    chk("wrap_retired", retired, 32'd0);
    chk("wrap_state", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
